// File: rtl/csa_pkg.sv
// Shared constants and types for the carry-select adder and the frame accumulator.
package csa_pkg;
  localparam int DATA_W    = 32;
  localparam int CSA_BLK_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } csa_acc_state_t;
endpackage

// File: rtl/carrySelectAdder.sv
// Carry-select adder: each block precomputes sums for carry-in 0 and 1,
// and the rippling block carry only drives the select muxes.
module carrySelectAdder
  import csa_pkg::*;
#(
  parameter int W     = DATA_W,
  parameter int BLK_W = CSA_BLK_W
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);
  localparam int NUM_BLK = W / BLK_W;

  logic [NUM_BLK:0] blk_c;

  assign blk_c[0] = cin;

  for (genvar g = 0; g < NUM_BLK; g++) begin : g_blk
    logic [BLK_W-1:0] a_b, b_b, s0, s1;
    logic             c0, c1;

    assign a_b       = a[g*BLK_W +: BLK_W];
    assign b_b       = b[g*BLK_W +: BLK_W];
    assign {c0, s0}  = {1'b0, a_b} + {1'b0, b_b};
    assign {c1, s1}  = {1'b0, a_b} + {1'b0, b_b} + {{BLK_W{1'b0}}, 1'b1};
    assign sum[g*BLK_W +: BLK_W] = blk_c[g] ? s1 : s0;
    assign blk_c[g+1]            = blk_c[g] ? c1 : c0;
  end

  assign cout = blk_c[NUM_BLK];
endmodule

// File: rtl/csa_accumulator.sv
// Frame accumulator: sums cfg_len+1 beats through the carry-select adder and
// presents the total plus a sticky carry-out flag on a valid/ready port.
module csa_accumulator
  import csa_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CNT_W-1:0]  cfg_len,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_sum,
  output logic              out_ovf
);
  csa_acc_state_t    state_q, state_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic              ovf_q, ovf_d;
  logic [CNT_W-1:0]  rem_q, rem_d;

  logic [DATA_W-1:0] add_sum;
  logic              add_cout;
  logic              beat;

  carrySelectAdder #(.W(DATA_W), .BLK_W(CSA_BLK_W)) u_add (
    .a    (acc_q),
    .b    (in_data),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

  assign in_ready  = (state_q == DONE) ? out_ready : 1'b1;
  assign out_valid = (state_q == DONE);
  assign out_sum   = acc_q;
  assign out_ovf   = ovf_q;
  assign beat      = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    rem_d   = rem_q;
    unique case (state_q)
      IDLE, DONE: begin
        // In DONE a beat implies out_ready, so the result is taken on the same edge.
        if (beat) begin
          acc_d   = in_data;
          ovf_d   = 1'b0;
          rem_d   = cfg_len;
          state_d = (cfg_len == '0) ? DONE : ACCUM;
        end else if (state_q == DONE && out_ready) begin
          state_d = IDLE;
        end
      end
      ACCUM: begin
        if (beat) begin
          acc_d = add_sum;
          ovf_d = ovf_q | add_cout;
          if (rem_q == CNT_W'(1)) state_d = DONE;
          else                    rem_d   = rem_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      rem_q   <= rem_d;
    end
  end
endmodule

// File: tb/tb_csa_accumulator.sv
// Directed bench for csa_accumulator: stimulus queues expected frame results,
// a negedge monitor pops and compares on every output handshake.
module tb_csa_accumulator;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [7:0]  cfg_len;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_sum;
  logic        out_ovf;

  typedef struct packed {
    logic [31:0] sum;
    logic        ovf;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  csa_accumulator #(.CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .cfg_len   (cfg_len),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every output handshake must match the oldest expected result.
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result: got sum 0x%08h ovf %0b, expected no result", out_sum, out_ovf);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (out_sum !== e.sum || out_ovf !== e.ovf) begin
          errors++;
          $display("FAIL result: got sum 0x%08h ovf %0b expected sum 0x%08h ovf %0b",
                   out_sum, out_ovf, e.sum, e.ovf);
        end
      end
    end
  end

  // Called and returning at posedge+1; holds the beat until it is accepted.
  task automatic send(input logic [31:0] d, input logic [7:0] len, output int waits);
    logic r;
    in_valid = 1'b1;
    in_data  = d;
    cfg_len  = len;
    waits    = 0;
    for (int k = 0; k < 50; k++) begin
      #1 r = in_ready;
      @(posedge clk);
      #1;
      if (r) return;
      waits++;
    end
    checks++;
    errors++;
    $display("FAIL send_timeout: beat 0x%08h not accepted within 50 cycles", d);
  endtask

  task automatic idle();
    in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] s, input logic o);
    exp_t e;
    e.sum = s;
    e.ovf = o;
    exp_q.push_back(e);
  endtask

  initial begin
    int w;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    cfg_len   = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out_sum", out_sum, 32'h0);
    chk("reset_out_ovf", 32'(out_ovf), 32'd0);

    // Single-beat frame
    push(32'h0000_1234, 1'b0);
    send(32'h0000_1234, 8'd0, w);
    chk("single_latency", 32'(out_valid), 32'd1);
    idle();
    chk("single_back_idle", 32'(out_valid), 32'd0);

    // Four-beat frame
    push(32'hA, 1'b0);
    send(32'd1, 8'd3, w);
    send(32'd2, 8'd3, w);
    send(32'd3, 8'd3, w);
    chk("four_not_early", 32'(out_valid), 32'd0);
    send(32'd4, 8'd3, w);
    chk("four_latency", 32'(out_valid), 32'd1);
    idle();

    // Overflow, then back-to-back frame clears the sticky flag
    push(32'h0000_0001, 1'b1);
    send(32'hFFFF_FFFF, 8'd1, w);
    send(32'h0000_0002, 8'd1, w);
    push(32'd5, 1'b0);
    send(32'd5, 8'd0, w);
    chk("ovf_next_no_wait", 32'(w), 32'd0);
    idle();

    // Backpressure: result held, input stalled
    push(32'h0000_000F, 1'b1);
    out_ready = 1'b0;
    send(32'hFFFF_FFFF, 8'd1, w);
    send(32'h0000_0010, 8'd1, w);
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_out_sum", out_sum, 32'h0000_000F);
      chk("bp_out_ovf", 32'(out_ovf), 32'd1);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    push(32'd7, 1'b0);
    send(32'd7, 8'd0, w);
    chk("bp_release_no_wait", 32'(w), 32'd0);
    chk("bp_new_valid", 32'(out_valid), 32'd1);
    chk("bp_new_sum", out_sum, 32'd7);
    idle();

    // Back-to-back frames of two beats
    push(32'h3, 1'b0);
    push(32'h30, 1'b0);
    push(32'h300, 1'b0);
    send(32'h1, 8'd1, w);   chk("b2b_bubble0", 32'(w), 32'd0);
    send(32'h2, 8'd1, w);   chk("b2b_bubble1", 32'(w), 32'd0);
    send(32'h10, 8'd1, w);  chk("b2b_bubble2", 32'(w), 32'd0);
    send(32'h20, 8'd1, w);  chk("b2b_bubble3", 32'(w), 32'd0);
    send(32'h100, 8'd1, w); chk("b2b_bubble4", 32'(w), 32'd0);
    send(32'h200, 8'd1, w); chk("b2b_bubble5", 32'(w), 32'd0);
    idle();

    // Reset mid-frame discards the partial frame
    send(32'd1, 8'd3, w);
    send(32'd2, 8'd3, w);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_out_sum", out_sum, 32'h0);
    push(32'd9, 1'b0);
    send(32'd9, 8'd0, w);
    chk("midrst_new_valid", 32'(out_valid), 32'd1);
    idle();

    repeat (3) @(posedge clk);
    #1;
    chk("all_results_seen", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/csa_accumulator.md
# csa_accumulator

Frame-based 32-bit accumulator sitting directly downstream of the team's 32-bit carry-select adder. It takes a stream of 32-bit operands over a valid/ready handshake and sums each frame of `cfg_len+1` beats using that adder. It presents the frame total and a sticky overflow flag on a valid/ready output port. Typical use is checksum and sample-sum generation feeding the rest of the arithmetic datapath.

## Interface
- `CNT_W`, default 8: width of the beat counter and `cfg_len`; maximum frame length is 2^CNT_W beats.

Ports:
- `clk` in 1: the only clock; all state changes on its rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `in_valid` in 1: operand beat valid.
- `in_ready` out 1: block can accept a beat.
- `in_data` in 32: unsigned operand.
- `cfg_len` in CNT_W: frame length minus one; sampled only on a frame's first accepted beat.
- `out_valid` out 1: frame result valid.
- `out_ready` in 1: consumer accepts the result.
- `out_sum` out 32: frame sum, modulo 2^32.
- `out_ovf` out 1: at least one carry-out occurred during the frame.

## Operation
- A beat is accepted when `in_valid && in_ready` at a rising edge. A result is taken when `out_valid && out_ready`.
- States:
  - `IDLE`: `in_ready`=1, `out_valid`=0.
  - `ACCUM`: `in_ready`=1, `out_valid`=0.
  - `DONE`: `out_valid`=1, `in_ready`=`out_ready`.
- First beat, accepted in `IDLE`, or in `DONE` together with a result take:
  - `acc <= in_data`, `ovf <= 0`, `remaining <= cfg_len`.
  - If `cfg_len`==0, go to `DONE`; else go to `ACCUM`.
- Beat in `ACCUM`:
  - `{c, s}` = adder(`acc`, `in_data`, cin=0); `acc <= s`; `ovf <= ovf | c`.
  - If `remaining`==1, go to `DONE`; else `remaining <= remaining-1`.
- `DONE`:
  - `out_sum`=`acc` and `out_ovf`=`ovf`, held stable while `out_valid && !out_ready`.
  - Take with no new beat: go to `IDLE`.
  - Take with a simultaneous beat: treat that beat as the first beat of the next frame (back-to-back frames, no bubble).
- Arithmetic:
  - Unsigned, modulo 2^32; no saturation.
  - Overflow is reported only through the sticky `out_ovf`.
  - `cfg_len` changes in mid-frame are ignored.
- Reset (`rst_n`=0 at an edge):
  - State goes to `IDLE`; `acc`, `ovf` and `remaining` go to 0.
  - A partial or pending frame is discarded silently; no result is emitted for it.
- Reset values after the reset edge: `in_ready`=1, `out_valid`=0, `out_sum`=0, `out_ovf`=0.

## Timing
- Input side: at most one beat per cycle.
- `in_ready` depends only on state and `out_ready`, never on `in_valid`.
- Latency: `out_valid` rises in the cycle after the last beat is accepted.
- A frame of N beats occupies N cycles of input and one output cycle. With `out_ready` held high, the output cycle overlaps the next frame's first beat, so sustained throughput is 1 beat/cycle.
- The adder path is combinational within one cycle: `acc` → adder → `acc`. There is no pipelining inside the adder.
- Backpressure: while `DONE` and `out_ready`=0, `in_ready`=0 and all state is frozen.

## Structure
- Shared package `csa_pkg`:
  - `DATA_W`=32.
  - State enum `csa_acc_state_t` {`IDLE`, `ACCUM`, `DONE`}.
- Sub-module: one instance of the existing 32-bit carry-select adder (`carrySelectAdder`), with `cin` tied 0.
  - A = `acc`, B = `in_data`.
  - `sum`/`cout` feed the accumulator register and the overflow OR.
  - No other sub-modules; the FSM, counter and registers stay in `csa_accumulator`.

## Test plan
- Single-beat frame: `cfg_len`=0, `in_data`=0x0000_1234, `out_ready`=1 → next cycle `out_valid`=1, `out_sum`=0x0000_1234, `out_ovf`=0; the following cycle returns to `IDLE`.
- Four-beat frame: `cfg_len`=3, data 1, 2, 3, 4 → `out_sum`=0xA, `out_ovf`=0, `out_valid` rises exactly one cycle after the 4th beat is accepted.
- Overflow: `cfg_len`=1, data 0xFFFF_FFFF then 0x0000_0002 → `out_sum`=0x0000_0001, `out_ovf`=1. The next frame (`cfg_len`=0, data 5) → `out_ovf`=0.
- Backpressure: hold `out_ready`=0 for 5 cycles in `DONE` → `in_ready`=0 and `out_sum`/`out_ovf` stable all 5 cycles. Raise `out_ready` with `in_valid`=1, data 7, `cfg_len`=0 → result taken and new result 7 valid the next cycle.
- Back-to-back: three frames of `cfg_len`=1 streamed with `in_valid`=`out_ready`=1 continuously → no input bubble; three results with the correct sums.
- Reset mid-frame: `cfg_len`=3, accept 2 beats, drive `rst_n`=0 for one edge → `in_ready`=1, `out_valid`=0, `out_sum`=0. No result is emitted for the aborted frame, and a new frame of data 9 (`cfg_len`=0) yields 9.
